// File: rtl/apogeo_pkg.sv
// Shared commit-path types: instruction packet, ROB entry, commit FIFO entry.
// packet_convert builds the ROB entry from an instruction packet and result.
package apogeo_pkg;

   localparam int MAX_COMMIT_CHANNELS = 8;
   localparam int RES_W = 32;

   typedef struct packed {
      logic [5:0] rob_tag;
      logic [4:0] reg_dest;
      logic       exc_valid;
      logic [3:0] exc_cause;
   } instr_packet_t;

   typedef struct packed {
      logic [5:0]       rob_tag;
      logic [RES_W-1:0] result;
      logic [4:0]       reg_dest;
      logic             exc_valid;
      logic [3:0]       exc_cause;
   } rob_entry_t;

   typedef struct packed {
      logic [RES_W-1:0] result;
      instr_packet_t    pkt;
      logic             fwd_ok;
   } commit_fifo_entry_t;

   function automatic rob_entry_t packet_convert(
      input instr_packet_t    p,
      input logic [RES_W-1:0] r
   );
      rob_entry_t e;
      e.rob_tag   = p.rob_tag;
      e.result    = r;
      e.reg_dest  = p.reg_dest;
      e.exc_valid = p.exc_valid;
      e.exc_cause = p.exc_cause;
      return e;
   endfunction

endpackage

// File: rtl/commit_fifo.sv
// Per-channel commit FIFO with fwd_ok invalidation and forwarding lookup.
// Ports: push/pop, head, empty/full/afull flags, inv_mask_i, fwd lookup.
module commit_fifo
   import apogeo_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int XLEN      = 32,
   parameter int FWD_PORTS = 2
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                flush_i,
   input  logic                                push_i,
   input  commit_fifo_entry_t                  entry_i,
   input  logic                                pop_i,
   input  logic [31:0]                         inv_mask_i,
   output logic [XLEN-1:0]                     head_res_o,
   output instr_packet_t                       head_pkt_o,
   output logic                                empty_o,
   output logic                                full_o,
   output logic                                afull_o,
   input  logic [FWD_PORTS-1:0][4:0]           fwd_src_i,
   output logic [FWD_PORTS-1:0]                fwd_hit_o,
   output logic [FWD_PORTS-1:0][XLEN-1:0]      fwd_data_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   commit_fifo_entry_t mem_q [DEPTH];
   logic [PW-1:0]      wr_q, rd_q, cnt;
   logic [DEPTH-1:0]   occ;
   logic [AW-1:0]      off;
   logic               push_ok, do_pop;

   assign cnt     = wr_q - rd_q;
   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                    (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign afull_o = (cnt >= PW'(DEPTH - 1));

   // A full FIFO may still accept a push when its head leaves this cycle.
   assign push_ok = push_i && (!full_o || pop_i);
   assign do_pop  = pop_i && !empty_o;

   assign head_res_o = mem_q[rd_q[AW-1:0]].result;
   assign head_pkt_o = mem_q[rd_q[AW-1:0]].pkt;

   // Slot i is live when its distance from the read pointer is below count.
   always_comb begin
      off = '0;
      occ = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off    = AW'(i) - rd_q[AW-1:0];
         occ[i] = ({1'b0, off} < cnt);
      end
   end

   always_comb begin
      fwd_hit_o  = '0;
      fwd_data_o = '0;
      for (int p = 0; p < FWD_PORTS; p++) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (occ[i] && mem_q[i].fwd_ok &&
                fwd_src_i[p] != 5'd0 &&
                mem_q[i].pkt.reg_dest == fwd_src_i[p]) begin
               fwd_hit_o[p]  = 1'b1;
               fwd_data_o[p] = mem_q[i].result;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         // Older copies of a register lose forwarding rights to the new write.
         for (int i = 0; i < DEPTH; i++) begin
            if (inv_mask_i[mem_q[i].pkt.reg_dest]) begin
               mem_q[i].fwd_ok <= 1'b0;
            end
         end
         if (push_ok) begin
            mem_q[wr_q[AW-1:0]] <= entry_i;
            wr_q <= wr_q + 1'b1;
         end
         if (do_pop) begin
            rd_q <= rd_q + 1'b1;
         end
      end
   end

   a_no_overflow: assert property (
      @(posedge clk_i) disable iff (rst_i || flush_i)
      !(push_i && full_o && !pop_i)
   );

endmodule

// File: rtl/commit_arbiter.sv
// N-channel commit stage: per-channel FIFOs drained round-robin to the ROB.
// Ports: channel results in, ROB write out, stall/flush, forwarding lookups.
module commit_arbiter
   import apogeo_pkg::*;
#(
   parameter int N_CHANNELS = 3,
   parameter int DEPTH      = 4,
   parameter int XLEN       = 32,
   parameter int FWD_PORTS  = 2
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              flush_i,
   input  logic                              stall_i,
   output logic                              stall_o,
   input  logic [N_CHANNELS-1:0]             valid_i,
   input  logic [N_CHANNELS-1:0][XLEN-1:0]   result_i,
   input  instr_packet_t [N_CHANNELS-1:0]    ipacket_i,
   output logic                              rob_write_o,
   output logic [5:0]                        rob_tag_o,
   output rob_entry_t                        rob_entry_o,
   output logic [N_CHANNELS-1:0]             grant_o,
   output logic                              buffers_empty_o,
   input  logic [FWD_PORTS-1:0][4:0]         fwd_src_i,
   output logic [FWD_PORTS-1:0][XLEN-1:0]    fwd_data_o,
   output logic [FWD_PORTS-1:0]              fwd_valid_o
);

   localparam int IW = $clog2(N_CHANNELS);

   logic [IW-1:0]                  rr_q, rr_d, gnt_idx;
   logic                           found, commit_en;
   logic [N_CHANNELS-1:0]          req, empty, afull;
   logic [N_CHANNELS-1:0]          push, pop, in_ok;
   logic [31:0]                    inv_mask;
   logic [XLEN-1:0]                head_res [N_CHANNELS];
   instr_packet_t                  head_pkt [N_CHANNELS];
   commit_fifo_entry_t             push_ent [N_CHANNELS];
   logic [FWD_PORTS-1:0]           f_hit    [N_CHANNELS];
   logic [FWD_PORTS-1:0][XLEN-1:0] f_data   [N_CHANNELS];
   instr_packet_t                  sel_pkt;
   logic [XLEN-1:0]                sel_res;

   assign req             = ~empty | valid_i;
   assign stall_o         = |afull;
   assign buffers_empty_o = &empty;

   // Cyclic search for the first requester at or after rr_q.
   always_comb begin
      int j;
      found   = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < N_CHANNELS; k++) begin
         j = int'(rr_q) + k;
         if (j >= N_CHANNELS) j = j - N_CHANNELS;
         if (!found && req[j]) begin
            found   = 1'b1;
            gnt_idx = IW'(j);
         end
      end
   end

   assign commit_en = !rst_i && !stall_i && !flush_i && found;

   // Empty granted FIFO means the live input bypasses straight to the ROB.
   always_comb begin
      sel_pkt = ipacket_i[gnt_idx];
      sel_res = result_i[gnt_idx];
      if (!empty[gnt_idx]) begin
         sel_pkt = head_pkt[gnt_idx];
         sel_res = head_res[gnt_idx];
      end
   end

   always_comb begin
      grant_o     = '0;
      rob_write_o = commit_en;
      rob_tag_o   = '0;
      rob_entry_o = '0;
      if (commit_en) begin
         grant_o[gnt_idx] = 1'b1;
         rob_tag_o        = sel_pkt.rob_tag;
         rob_entry_o      = packet_convert(sel_pkt, sel_res);
      end
   end

   assign pop  = grant_o & ~empty;
   assign push = valid_i & ~(grant_o & empty) & {N_CHANNELS{!flush_i}};

   // Among same-cycle writers of one register the highest tag wins.
   always_comb begin
      in_ok    = valid_i;
      inv_mask = '0;
      for (int c = 0; c < N_CHANNELS; c++) begin
         if (valid_i[c]) inv_mask[ipacket_i[c].reg_dest] = 1'b1;
         for (int o = 0; o < N_CHANNELS; o++) begin
            if (o != c && valid_i[o] &&
                ipacket_i[o].reg_dest == ipacket_i[c].reg_dest &&
                ipacket_i[o].rob_tag > ipacket_i[c].rob_tag) begin
               in_ok[c] = 1'b0;
            end
         end
      end
   end

   always_comb begin
      for (int c = 0; c < N_CHANNELS; c++) begin
         push_ent[c].result = result_i[c];
         push_ent[c].pkt    = ipacket_i[c];
         push_ent[c].fwd_ok = in_ok[c];
      end
   end

   for (genvar c = 0; c < N_CHANNELS; c++) begin : g_fifo
      commit_fifo #(
         .DEPTH     (DEPTH),
         .XLEN      (XLEN),
         .FWD_PORTS (FWD_PORTS)
      ) u_fifo (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .flush_i    (flush_i),
         .push_i     (push[c]),
         .entry_i    (push_ent[c]),
         .pop_i      (pop[c]),
         .inv_mask_i (inv_mask),
         .head_res_o (head_res[c]),
         .head_pkt_o (head_pkt[c]),
         .empty_o    (empty[c]),
         .full_o     (),
         .afull_o    (afull[c]),
         .fwd_src_i  (fwd_src_i),
         .fwd_hit_o  (f_hit[c]),
         .fwd_data_o (f_data[c])
      );
   end

   // Live inputs beat buffered entries; buffered hits are unique.
   always_comb begin
      logic hit;
      fwd_valid_o = '0;
      fwd_data_o  = '0;
      for (int p = 0; p < FWD_PORTS; p++) begin
         hit = 1'b0;
         if (!rst_i && fwd_src_i[p] != 5'd0) begin
            for (int c = 0; c < N_CHANNELS; c++) begin
               if (in_ok[c] && ipacket_i[c].reg_dest == fwd_src_i[p]) begin
                  hit           = 1'b1;
                  fwd_data_o[p] = result_i[c];
               end
            end
            for (int c = 0; c < N_CHANNELS; c++) begin
               if (!hit && f_hit[c][p]) begin
                  fwd_data_o[p] = f_data[c][p];
               end
            end
            for (int c = 0; c < N_CHANNELS; c++) begin
               if (f_hit[c][p]) hit = 1'b1;
            end
         end
         fwd_valid_o[p] = hit;
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (flush_i) begin
         rr_d = '0;
      end else if (commit_en) begin
         rr_d = (gnt_idx == IW'(N_CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) rr_q <= '0;
      else       rr_q <= rr_d;
   end

endmodule

// File: tb/tb_commit_arbiter.sv
// Directed bench for commit_arbiter: bypass, round-robin, stall, forwarding,
// flush and reset behaviour with hand-computed expectations.
module tb_commit_arbiter;
   import apogeo_pkg::*;

   logic                  clk_i = 1'b0;
   logic                  rst_i;
   logic                  flush_i;
   logic                  stall_i;
   logic                  stall_o;
   logic [2:0]            valid_i;
   logic [2:0][31:0]      result_i;
   instr_packet_t [2:0]   ipacket_i;
   logic                  rob_write_o;
   logic [5:0]            rob_tag_o;
   rob_entry_t            rob_entry_o;
   logic [2:0]            grant_o;
   logic                  buffers_empty_o;
   logic [1:0][4:0]       fwd_src_i;
   logic [1:0][31:0]      fwd_data_o;
   logic [1:0]            fwd_valid_o;

   int n_tests = 0;
   int n_fail  = 0;

   commit_arbiter #(
      .N_CHANNELS (3),
      .DEPTH      (4),
      .XLEN       (32),
      .FWD_PORTS  (2)
   ) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .flush_i         (flush_i),
      .stall_i         (stall_i),
      .stall_o         (stall_o),
      .valid_i         (valid_i),
      .result_i        (result_i),
      .ipacket_i       (ipacket_i),
      .rob_write_o     (rob_write_o),
      .rob_tag_o       (rob_tag_o),
      .rob_entry_o     (rob_entry_o),
      .grant_o         (grant_o),
      .buffers_empty_o (buffers_empty_o),
      .fwd_src_i       (fwd_src_i),
      .fwd_data_o      (fwd_data_o),
      .fwd_valid_o     (fwd_valid_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clr();
      valid_i   = '0;
      result_i  = '0;
      ipacket_i = '0;
   endtask

   task automatic set_ch(input int ch, input logic [5:0] tag,
                         input logic [4:0] rd, input logic [31:0] res);
      valid_i[ch]            = 1'b1;
      result_i[ch]           = res;
      ipacket_i[ch].rob_tag  = tag;
      ipacket_i[ch].reg_dest = rd;
   endtask

   task automatic do_reset();
      rst_i     = 1'b1;
      flush_i   = 1'b0;
      stall_i   = 1'b0;
      fwd_src_i = '0;
      clr();
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   task automatic chk_commit(input string tag, input logic [2:0] g,
                             input logic [5:0] rt);
      chk({tag, "_wr"},  64'(rob_write_o), 64'(1));
      chk({tag, "_gnt"}, 64'(grant_o), 64'(g));
      chk({tag, "_tag"}, 64'(rob_tag_o), 64'(rt));
   endtask

   initial begin
      logic [5:0] exp_tag;

      // Reset state, with live inputs that must not leak out.
      do_reset();
      rst_i = 1'b1;
      set_ch(0, 6'd1, 5'd3, 32'h1);
      fwd_src_i[0] = 5'd3;
      #2;
      chk("rst_wr",    64'(rob_write_o), 64'(0));
      chk("rst_gnt",   64'(grant_o), 64'(0));
      chk("rst_entry", 64'(rob_entry_o), 64'(0));
      chk("rst_empty", 64'(buffers_empty_o), 64'(1));
      chk("rst_stall", 64'(stall_o), 64'(0));
      chk("rst_fwdv",  64'(fwd_valid_o), 64'(0));
      chk("rst_fwdd",  64'(fwd_data_o), 64'(0));

      // Single-channel bypass.
      do_reset();
      set_ch(0, 6'd5, 5'd3, 32'hA5);
      #2;
      chk_commit("byp", 3'b001, 6'd5);
      chk("byp_res", 64'(rob_entry_o.result), 64'hA5);
      tick();
      clr();
      #2;
      chk("byp_nopush", 64'(buffers_empty_o), 64'(1));
      chk("byp_idle",   64'(rob_write_o), 64'(0));

      // Three channels at once, round-robin from 0.
      do_reset();
      set_ch(0, 6'd1, 5'd1, 32'h10);
      set_ch(1, 6'd2, 5'd2, 32'h20);
      set_ch(2, 6'd3, 5'd3, 32'h30);
      #2;
      chk_commit("rr0", 3'b001, 6'd1);
      tick();
      clr();
      #2;
      chk_commit("rr1", 3'b010, 6'd2);
      chk("rr1_res", 64'(rob_entry_o.result), 64'h20);
      tick();
      #2;
      chk_commit("rr2", 3'b100, 6'd3);
      tick();
      #2;
      chk("rr_done_wr",    64'(rob_write_o), 64'(0));
      chk("rr_done_empty", 64'(buffers_empty_o), 64'(1));

      // ROB stall while channel 1 fills its FIFO.
      do_reset();
      stall_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         clr();
         set_ch(1, 6'(10 + k), 5'd4, 32'(32'h100 + k));
         #2;
         chk($sformatf("stl_wr%0d", k), 64'(rob_write_o), 64'(0));
         chk($sformatf("stl_so%0d", k), 64'(stall_o), 64'(k == 3));
         tick();
      end
      stall_i = 1'b0;
      clr();
      for (int k = 0; k < 4; k++) begin
         #2;
         exp_tag = 6'(10 + k);
         chk_commit($sformatf("drn%0d", k), 3'b010, exp_tag);
         chk($sformatf("drn_res%0d", k), 64'(rob_entry_o.result),
             64'(32'h100 + k));
         chk($sformatf("drn_so%0d", k), 64'(stall_o), 64'(k < 2));
         tick();
      end
      #2;
      chk("drn_empty", 64'(buffers_empty_o), 64'(1));

      // Forwarding and invalidation of an older buffered copy.
      do_reset();
      stall_i = 1'b1;
      set_ch(0, 6'd4, 5'd7, 32'h11);
      fwd_src_i[0] = 5'd7;
      fwd_src_i[1] = 5'd0;
      #2;
      chk("fw_in_v", 64'(fwd_valid_o), 64'(2'b01));
      chk("fw_in_d", 64'(fwd_data_o[0]), 64'h11);
      tick();
      clr();
      set_ch(2, 6'd6, 5'd7, 32'h22);
      #2;
      chk("fw_new_d",  64'(fwd_data_o[0]), 64'h22);
      chk("fw_new_v",  64'(fwd_valid_o[0]), 64'(1));
      chk("fw_x0_v",   64'(fwd_valid_o[1]), 64'(0));
      chk("fw_x0_d",   64'(fwd_data_o[1]), 64'(0));
      tick();
      clr();
      fwd_src_i[1] = 5'd7;
      #2;
      chk("fw_buf_d0", 64'(fwd_data_o[0]), 64'h22);
      chk("fw_buf_d1", 64'(fwd_data_o[1]), 64'h22);
      chk("fw_buf_v",  64'(fwd_valid_o), 64'(2'b11));
      fwd_src_i[0] = 5'd9;
      #1;
      chk("fw_miss_v", 64'(fwd_valid_o[0]), 64'(0));
      chk("fw_miss_d", 64'(fwd_data_o[0]), 64'(0));
      tick();
      stall_i      = 1'b0;
      fwd_src_i[0] = 5'd7;
      #2;
      chk_commit("fw_c0", 3'b001, 6'd4);
      chk("fw_c0_res", 64'(rob_entry_o.result), 64'h11);
      chk("fw_c0_fwd", 64'(fwd_data_o[0]), 64'h22);
      tick();
      #2;
      chk_commit("fw_c2", 3'b100, 6'd6);
      tick();

      // Same-cycle writers of x5: higher tag wins, also once buffered.
      stall_i = 1'b1;
      set_ch(0, 6'd9, 5'd5, 32'h55);
      set_ch(1, 6'd8, 5'd5, 32'h66);
      fwd_src_i[0] = 5'd5;
      #2;
      chk("fw_sim_in",  64'(fwd_data_o[0]), 64'h55);
      tick();
      clr();
      #2;
      chk("fw_sim_buf", 64'(fwd_data_o[0]), 64'h55);
      chk("fw_sim_v",   64'(fwd_valid_o[0]), 64'(1));

      // Flush with two entries per channel; rr pointer returns to 0.
      do_reset();
      set_ch(0, 6'd1, 5'd1, 32'h1);
      #2;
      chk_commit("fl_pre", 3'b001, 6'd1);
      tick();
      stall_i = 1'b1;
      for (int k = 0; k < 2; k++) begin
         clr();
         for (int c = 0; c < 3; c++) begin
            set_ch(c, 6'(2 + 3 * k + c), 5'(c + 1), 32'(c));
         end
         tick();
      end
      stall_i = 1'b0;
      flush_i = 1'b1;
      clr();
      for (int c = 0; c < 3; c++) begin
         set_ch(c, 6'(8 + c), 5'(c + 1), 32'(c));
      end
      #2;
      chk("fl_wr",    64'(rob_write_o), 64'(0));
      chk("fl_gnt",   64'(grant_o), 64'(0));
      chk("fl_full",  64'(buffers_empty_o), 64'(0));
      tick();
      flush_i = 1'b0;
      clr();
      #2;
      chk("fl_empty", 64'(buffers_empty_o), 64'(1));
      chk("fl_idle",  64'(rob_write_o), 64'(0));
      for (int c = 0; c < 3; c++) begin
         set_ch(c, 6'(11 + c), 5'(c + 1), 32'(c));
      end
      #1;
      chk_commit("fl_rr0", 3'b001, 6'd11);
      tick();
      clr();

      // Asynchronous reset while channel 0 holds three entries.
      do_reset();
      stall_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         clr();
         set_ch(0, 6'(20 + k), 5'd6, 32'(k));
         tick();
      end
      clr();
      #1;
      chk("mr_so",    64'(stall_o), 64'(1));
      chk("mr_full",  64'(buffers_empty_o), 64'(0));
      stall_i = 1'b0;
      rst_i   = 1'b1;
      #1;
      chk("mr_empty", 64'(buffers_empty_o), 64'(1));
      chk("mr_wr",    64'(rob_write_o), 64'(0));
      chk("mr_so0",   64'(stall_o), 64'(0));
      tick();
      rst_i = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #2;
         chk($sformatf("mr_post_wr%0d", k), 64'(rob_write_o), 64'(0));
         chk($sformatf("mr_post_em%0d", k), 64'(buffers_empty_o), 64'(1));
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/commit_arbiter.md
Name: commit_arbiter

Overview:
- N-channel successor of the two-buffer commit stage.
- Sits between the execution units (ALU/CSR, LSU, FPU, ...) and the reorder buffer.
- Each execution channel owns a parametrised commit FIFO; a round-robin arbiter drains one result per cycle into the ROB, with same-cycle bypass when the granted FIFO is empty.
- Also serves two operand-forwarding read ports from in-flight inputs and buffered results.

Parameters:
- N_CHANNELS, 3, number of execution result channels (2..8).
- DEPTH, 4, entries per channel FIFO (power of two, >= 2).
- XLEN, 32, result width in bits.
- FWD_PORTS, 2, number of forwarding source lookups.

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- flush_i  in  1  synchronous flush of all FIFOs
- stall_i  in  1  ROB cannot accept a write this cycle
- stall_o  out  1  backpressure to execution units
- valid_i  in  N_CHANNELS  per-channel result valid
- result_i  in  N_CHANNELS x XLEN  per-channel result
- ipacket_i  in  N_CHANNELS x instr_packet_t  per-channel instruction packet (rob_tag, reg_dest, exception info)
- rob_write_o  out  1  ROB write strobe
- rob_tag_o  out  6  ROB slot of the written entry
- rob_entry_o  out  rob_entry_t  packet_convert(ipacket, result)
- grant_o  out  N_CHANNELS  one-hot channel committed this cycle (debug/perf)
- buffers_empty_o  out  1  all FIFOs empty
- fwd_src_i  in  FWD_PORTS x 5  register sources to look up
- fwd_data_o  out  FWD_PORTS x XLEN  forwarded value
- fwd_valid_o  out  FWD_PORTS  forwarded value valid

Behaviour:
- Reset (rst_i high, async): all FIFOs empty, round-robin pointer = 0, forwarding valid bits cleared. Reset also clears the FIFOs while asserted mid-operation.
- Output values during reset and whenever idle: rob_write_o=0, rob_tag_o=0, rob_entry_o='0, grant_o=0, stall_o=0, buffers_empty_o=1, fwd_valid_o=0, fwd_data_o=0.
- Request of channel c: req[c] = !empty[c] | valid_i[c].
- Grant: first requesting channel at or after rr_ptr, cyclic search. rr_ptr updates to (granted+1) mod N_CHANNELS only when rob_write_o=1.
- Granted channel, FIFO not empty: pop head; ROB receives the head. valid_i[c] in the same cycle is pushed (simultaneous push/pop, count unchanged).
- Granted channel, FIFO empty: bypass valid_i[c] straight to the ROB, no push. Latency = 0 cycles combinational to the ROB; 1 cycle minimum through a FIFO.
- Non-granted channels with valid_i: push into their FIFO.
- stall_i=1: no pop, no bypass, rob_write_o=0, rr_ptr held; all valid inputs are pushed.
- stall_o = OR over channels of (count >= DEPTH-1). This gives one cycle of slack. Execution units must not assert valid_i while stall_o was high in the previous cycle. A push into a full FIFO is a protocol error (assertion), and the data is dropped.
- flush_i: the FIFOs are cleared at the next edge, rr_ptr reset to 0, and inputs in that cycle are discarded. rob_write_o is forced 0 during flush.
- FIFO pointers are log2(DEPTH)+1 bits; wrap-around detected by the MSB; full when the MSBs differ and the low bits are equal.
- Invalidation: every entry carries an fwd_ok bit, set on push. When any channel writes (push or bypass) reg_dest R, every buffered entry with reg_dest R in all FIFOs clears fwd_ok. Of simultaneous inputs, the one with the higher ROB tag age wins.
- Forwarding per port p, in priority order:
  - fwd_src_i[p]==0: fwd_valid_o=0.
  - Else an incoming valid_i[c] with matching reg_dest: forward result_i[c].
  - Else a buffered entry with matching reg_dest and fwd_ok=1 in any FIFO (at most one by invariant): forward its result.
  - Else fwd_valid_o=0, fwd_data_o=0.
- buffers_empty_o = AND of empty[c]; it reflects registered state only.

Decomposition:
- apogeo_pkg gains:
  - commit_fifo_entry_t: result, instr_packet_t, fwd_ok.
  - Parameter-independent constant MAX_COMMIT_CHANNELS=8.
- rob_entry_t, instr_packet_t and packet_convert are reused from the package unchanged.
- Sub-module commit_fifo (parameters DEPTH, XLEN) contains:
  - storage and pointers;
  - full/empty/almost-full flags;
  - invalidate port;
  - FWD_PORTS associative lookup.
- commit_arbiter holds the round-robin grant, bypass mux, stall and flush logic, and the final forwarding priority mux.

Test Plan:
- Reset mid-traffic: rst_i pulsed while FIFOs hold 3 entries -> buffers_empty_o=1 and rob_write_o=0 immediately; no entry is committed after release.
- Single channel, empty FIFOs: valid_i=001, tag 5, result 0xA5 -> same cycle rob_write_o=1, rob_tag_o=5, grant_o=001, no push.
- All three channels valid in one cycle, rr_ptr=0, tags 1/2/3 -> commits tags 1, 2, 3 on cycles 0, 1, 2; grant_o sequence 001, 010, 100.
- stall_i high 4 cycles while ch1 pushes every cycle -> stall_o high from the cycle count reaches 3; no overflow; 4 entries drain in order after release.
- Forwarding: ch0 buffered x7=0x11, then ch2 pushes x7=0x22 -> fwd_src_i=7 returns 0x22 in the push cycle and afterwards; the old entry's fwd_ok=0; fwd_src_i=0 -> fwd_valid_o=0.
- flush_i with 2 entries per channel and valid_i=111 -> next cycle buffers_empty_o=1, rr_ptr=0, no ROB write during the flush cycle.
